// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: default widths, bit-order encodings and
// legal-range limits used by the RX datapath blocks.
package uart_rx_pkg;
    localparam int   DATA_WIDTH_DEF = 8;
    localparam int   PRESCALE_W_DEF = 6;
    localparam logic LSB_FIRST      = 1'b0;
    localparam logic MSB_FIRST      = 1'b1;
    localparam int   PRESCALE_MIN   = 4;
    localparam int   DATA_LEN_MIN   = 1;
endpackage

// File: rtl/uart_rx_bit_strobe.sv
// Bit-sampling strobe: fires once per bit period, on the last oversample
// edge. Shared by the deserializer and the stop/parity checkers.
module uart_rx_bit_strobe
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  new_bit
);
    logic [PRESCALE_W-1:0] last_edge;

    // Compare at full width; prescale=0 would wrap to all-ones, so it is excluded.
    always_comb begin
        last_edge = prescale - PRESCALE_W'(1);
        new_bit   = en && (prescale != '0) && (edge_cnt == last_edge);
    end
endmodule

// File: rtl/uart_rx_deser_cfg.sv
// Configurable UART RX deserializer: runtime frame length and bit order,
// word presented right-justified on P_DATA with a one-cycle data_valid.
// Optional running-parity output enabled by UART_RX_DESER_PARITY_EN.
module uart_rx_deser_cfg
    import uart_rx_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int PRESCALE_W = PRESCALE_W_DEF,
    localparam int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  deser_en,
    input  logic                  sampled_bit,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [LEN_W-1:0]      data_len,
    input  logic                  msb_first,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic [LEN_W-1:0]      bit_cnt,
    output logic                  frame_done
`ifdef UART_RX_DESER_PARITY_EN
    ,
    output logic                  par_bit
`endif
);
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d, shadow_nxt;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  order_q, order_d;
    logic [LEN_W-1:0]      len_clamped, len_eff;
    logic                  order_eff;
    logic                  new_bit, first_bit, last_bit;

    uart_rx_bit_strobe #(
        .PRESCALE_W (PRESCALE_W)
    ) u_strobe (
        .en       (deser_en && !done_q),
        .edge_cnt (edge_cnt),
        .prescale (prescale),
        .new_bit  (new_bit)
    );

    // Out-of-range frame lengths fall back to the full word width.
    always_comb begin
        len_clamped = data_len;
        if ((data_len < LEN_W'(DATA_LEN_MIN)) || (data_len > LEN_W'(DATA_WIDTH))) begin
            len_clamped = LEN_W'(DATA_WIDTH);
        end
    end

    // Capture, completion and abort control; the first bit uses live config.
    always_comb begin
        shadow_d  = shadow_q;
        p_data_d  = p_data_q;
        valid_d   = 1'b0;
        done_d    = done_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        order_d   = order_q;
        first_bit = new_bit && (cnt_q == '0);
        len_eff   = first_bit ? len_clamped : len_q;
        order_eff = first_bit ? msb_first : order_q;

        shadow_nxt = first_bit ? '0 : shadow_q;
        if (order_eff == MSB_FIRST) begin
            shadow_nxt = {shadow_nxt[DATA_WIDTH-2:0], sampled_bit};
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (LEN_W'(i) == cnt_q) begin
                    shadow_nxt[i] = sampled_bit;
                end
            end
        end
        last_bit = new_bit && (cnt_q == (len_eff - LEN_W'(1)));

        if (!deser_en) begin
            cnt_d    = '0;
            done_d   = 1'b0;
            shadow_d = '0;
        end else if (new_bit) begin
            shadow_d = shadow_nxt;
            if (first_bit) begin
                len_d   = len_clamped;
                order_d = msb_first;
            end
            if (last_bit) begin
                cnt_d    = '0;
                done_d   = 1'b1;
                p_data_d = shadow_nxt;
                valid_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + LEN_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            shadow_q <= '0;
            p_data_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            len_q    <= LEN_W'(DATA_WIDTH);
            order_q  <= LSB_FIRST;
        end else begin
            shadow_q <= shadow_d;
            p_data_q <= p_data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            order_q  <= order_d;
        end
    end

`ifdef UART_RX_DESER_PARITY_EN
    logic par_q, par_d;

    // Running XOR of captured bits; cleared with the shadow, frozen once done.
    always_comb begin
        par_d = par_q;
        if (!deser_en) begin
            par_d = 1'b0;
        end else if (new_bit) begin
            par_d = (first_bit ? 1'b0 : par_q) ^ sampled_bit;
        end
    end

    // Parity register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_bit = par_q;
`endif

    assign P_DATA     = p_data_q;
    assign data_valid = valid_q;
    assign bit_cnt    = cnt_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_uart_rx_deser_cfg.sv
// Self-checking bench for uart_rx_deser_cfg (define UART_RX_DESER_PARITY_EN
// to also check par_bit).
module tb_uart_rx_deser_cfg;
    localparam int DW = 8;
    localparam int PW = 6;
    localparam int LW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          deser_en = 1'b0;
    logic          sampled_bit = 1'b0;
    logic [PW-1:0] edge_cnt = '0;
    logic [PW-1:0] prescale = PW'(8);
    logic [LW-1:0] data_len = LW'(8);
    logic          msb_first = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic [LW-1:0] bit_cnt;
    logic          frame_done;
`ifdef UART_RX_DESER_PARITY_EN
    logic          par_bit;
`endif

    int tests = 0;
    int fails = 0;
    int vld_cnt = 0;

    uart_rx_deser_cfg #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .deser_en    (deser_en),
        .sampled_bit (sampled_bit),
        .edge_cnt    (edge_cnt),
        .prescale    (prescale),
        .data_len    (data_len),
        .msb_first   (msb_first),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .bit_cnt     (bit_cnt),
        .frame_done  (frame_done)
`ifdef UART_RX_DESER_PARITY_EN
        ,
        .par_bit     (par_bit)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (data_valid === 1'b1) vld_cnt++;

    // Reference: word value from transmitted bit sequence.
    function automatic logic [7:0] expect_word(input logic [15:0] bits, input int n, input logic msb);
        int w;
        w = 0;
        for (int i = 0; i < n; i++) begin
            if (msb) w = w * 2 + int'(bits[4'(i)]);
            else     w = w + (int'(bits[4'(i)]) << i);
        end
        return 8'(w);
    endfunction

    function automatic logic expect_par(input logic [15:0] bits, input int n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < n; i++) p = p ^ bits[4'(i)];
        return p;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Drive n bit periods of ps oversample edges; bits[i] is the i-th bit sent.
    task automatic send_bits(input logic [15:0] bits, input int n, input int ps);
        deser_en = 1'b1;
        prescale = PW'(ps);
        for (int i = 0; i < n; i++) begin
            for (int e = 0; e < ps; e++) begin
                edge_cnt    = PW'(e);
                sampled_bit = bits[4'(i)];
                tick();
            end
        end
        edge_cnt = '0;
    endtask

    task automatic end_frame;
        deser_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        RST = 1'b0;
        prescale = PW'(8);
        for (int i = 0; i < 12; i++) begin
            deser_en    = 1'b1;
            sampled_bit = 1'(i % 2);
            edge_cnt    = PW'(i % 8);
            tick();
            tests++;
            if ({P_DATA, data_valid, bit_cnt, frame_done} !== 14'h0) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d got P_DATA=%h vld=%b cnt=%0d done=%b want all 0", i, P_DATA, data_valid, bit_cnt, frame_done);
            end
        end
        deser_en = 1'b0;
        edge_cnt = '0;
        RST = 1'b1;
        tick();
        tick();
        tests++;
        if ({P_DATA, data_valid, bit_cnt, frame_done} !== 14'h0) begin
            fails++;
            $display("FAIL reset_release got P_DATA=%h vld=%b cnt=%0d done=%b want all 0", P_DATA, data_valid, bit_cnt, frame_done);
        end
    endtask

    task automatic test_legacy;
        int v0;
        logic [15:0] bits;
        bits = 16'h00A5;
        data_len = LW'(8);
        msb_first = 1'b0;
        v0 = vld_cnt;
        send_bits(bits, 8, 8);
        tests++;
        if (P_DATA !== expect_word(bits, 8, 1'b0) || P_DATA !== 8'hA5) begin
            fails++;
            $display("FAIL legacy_data got %h want a5", P_DATA);
        end
        tests++;
        if ({data_valid, frame_done, bit_cnt} !== {1'b1, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL legacy_status got vld=%b done=%b cnt=%0d want 1 1 0", data_valid, frame_done, bit_cnt);
        end
`ifdef UART_RX_DESER_PARITY_EN
        tests++;
        if (par_bit !== 1'b0) begin
            fails++;
            $display("FAIL legacy_par got %b want 0", par_bit);
        end
`endif
        tick();
        tests++;
        if (data_valid !== 1'b0 || (vld_cnt - v0) !== 1) begin
            fails++;
            $display("FAIL legacy_pulse got vld=%b pulses=%0d want 0 and 1", data_valid, vld_cnt - v0);
        end
        end_frame();
    endtask

    task automatic test_msb7;
        logic [15:0] bits;
        bits = 16'b0000_0000_0101_0011;  // sent 1,1,0,0,1,0,1
        data_len = LW'(7);
        msb_first = 1'b1;
        send_bits(bits, 7, 16);
        tests++;
        if (P_DATA !== expect_word(bits, 7, 1'b1) || P_DATA !== 8'h65 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL msb7 got P_DATA=%h vld=%b want 65 1", P_DATA, data_valid);
        end
        end_frame();
    endtask

    task automatic test_lsb5;
        logic [15:0] bits;
        bits = 16'b0000_0000_0001_1001;  // sent 1,0,0,1,1
        data_len = LW'(5);
        msb_first = 1'b0;
        send_bits(bits, 5, 8);
        tests++;
        if (P_DATA !== expect_word(bits, 5, 1'b0) || P_DATA !== 8'h19 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL lsb5 got P_DATA=%h vld=%b want 19 1", P_DATA, data_valid);
        end
        end_frame();
    endtask

    task automatic test_abort;
        int v0;
        data_len = LW'(8);
        msb_first = 1'b0;
        send_bits(16'h003C, 8, 8);
        end_frame();
        tests++;
        if (P_DATA !== 8'h3C) begin
            fails++;
            $display("FAIL abort_prior got %h want 3c", P_DATA);
        end
        v0 = vld_cnt;
        send_bits(16'h0005, 4, 8);
        tests++;
        if (bit_cnt !== LW'(4)) begin
            fails++;
            $display("FAIL abort_midcnt got %0d want 4", bit_cnt);
        end
        deser_en = 1'b0;
        tick();
        tick();
        tests++;
        if (P_DATA !== 8'h3C || bit_cnt !== 4'd0 || (vld_cnt - v0) !== 0) begin
            fails++;
            $display("FAIL abort_discard got P_DATA=%h cnt=%0d pulses=%0d want 3c 0 0", P_DATA, bit_cnt, vld_cnt - v0);
        end
        send_bits(16'h00FF, 8, 8);
        tests++;
        if (P_DATA !== 8'hFF || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL abort_next got P_DATA=%h vld=%b want ff 1", P_DATA, data_valid);
        end
        end_frame();
    endtask

    task automatic test_overrun_config;
        int v0;
        logic [15:0] w;
        w = 16'($urandom_range(0, 255));
        data_len = LW'(8);
        msb_first = 1'b0;
        v0 = vld_cnt;
        send_bits(w, 2, 6);
        data_len = LW'(3);
        tests++;
        if (bit_cnt !== LW'(2)) begin
            fails++;
            $display("FAIL cfg_midcnt got %0d want 2", bit_cnt);
        end
        send_bits(w >> 2, 6, 6);
        tests++;
        if (P_DATA !== expect_word(w, 8, 1'b0) || data_valid !== 1'b1 || (vld_cnt - v0) !== 0) begin
            fails++;
            $display("FAIL cfg_latched got P_DATA=%h vld=%b early=%0d want %h 1 0", P_DATA, data_valid, vld_cnt - v0, expect_word(w, 8, 1'b0));
        end
        tick();
        v0 = vld_cnt;
        send_bits(16'hFFFF, 3, 6);
        tick();
        tests++;
        if (P_DATA !== expect_word(w, 8, 1'b0) || frame_done !== 1'b1 || bit_cnt !== 4'd0 || (vld_cnt - v0) !== 0) begin
            fails++;
            $display("FAIL overrun got P_DATA=%h done=%b cnt=%0d pulses=%0d", P_DATA, frame_done, bit_cnt, vld_cnt - v0);
        end
`ifdef UART_RX_DESER_PARITY_EN
        tests++;
        if (par_bit !== expect_par(w, 8)) begin
            fails++;
            $display("FAIL overrun_par got %b want %b", par_bit, expect_par(w, 8));
        end
`endif
        end_frame();
        data_len = LW'(8);
    endtask

    task automatic test_prescale_zero;
        int v0;
        v0 = vld_cnt;
        deser_en = 1'b1;
        prescale = '0;
        for (int e = 0; e < 64; e++) begin
            edge_cnt = PW'(e);
            sampled_bit = 1'b1;
            tick();
        end
        tests++;
        if (bit_cnt !== 4'd0 || (vld_cnt - v0) !== 0) begin
            fails++;
            $display("FAIL prescale_zero got cnt=%0d pulses=%0d want 0 0", bit_cnt, vld_cnt - v0);
        end
        end_frame();
    endtask

`ifdef UART_RX_DESER_PARITY_EN
    task automatic test_parity;
        data_len = LW'(8);
        msb_first = 1'b0;
        send_bits(16'h00A4, 8, 8);
        tests++;
        if (par_bit !== 1'b1 || P_DATA !== 8'hA4) begin
            fails++;
            $display("FAIL parity_a4 got par=%b P_DATA=%h want 1 a4", par_bit, P_DATA);
        end
        end_frame();
    endtask
`endif

    task automatic test_random;
        logic [15:0] bits;
        int len_in, n, ps;
        logic msb;
        for (int k = 0; k < 24; k++) begin
            len_in = $urandom_range(0, 15);
            n = (len_in == 0 || len_in > DW) ? DW : len_in;
            msb = 1'($urandom_range(0, 1));
            ps = $urandom_range(4, 12);
            bits = 16'($urandom);
            data_len = LW'(len_in);
            msb_first = msb;
            send_bits(bits, n, ps);
            tests++;
            if (P_DATA !== expect_word(bits, n, msb) || data_valid !== 1'b1 || frame_done !== 1'b1) begin
                fails++;
                $display("FAIL random k=%0d len=%0d msb=%b got P_DATA=%h vld=%b done=%b want %h", k, len_in, msb, P_DATA, data_valid, frame_done, expect_word(bits, n, msb));
            end
`ifdef UART_RX_DESER_PARITY_EN
            tests++;
            if (par_bit !== expect_par(bits, n)) begin
                fails++;
                $display("FAIL random_par k=%0d got %b want %b", k, par_bit, expect_par(bits, n));
            end
`endif
            end_frame();
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_msb7();
        test_lsb5();
        test_abort();
        test_overrun_config();
        test_prescale_zero();
`ifdef UART_RX_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
